// File: rtl/spi_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// spi_reg_arbiter_if : SPI, local-requester and bank-port bundle for the arbiter
// Revision 1.0
// ============================================================================
interface spi_reg_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic              spi_wen;
  logic              spi_ren;
  logic              spi_done;
  logic [DATA_W-1:0] spi_rdata;

  logic              lcl_req;
  logic              lcl_we;
  logic [ADDR_W-1:0] lcl_addr;
  logic [DATA_W-1:0] lcl_wdata;
  logic              lcl_gnt;
  logic              lcl_rvalid;
  logic [DATA_W-1:0] lcl_rdata;

  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_wdata;
  logic              bank_we;
  logic              bank_re;
  logic [DATA_W-1:0] bank_rdata;

  logic              cfg_commit;
  logic              spi_ovr;

  modport slave (
    input  spi_addr, spi_wdata, spi_wen, spi_ren, spi_done,
    input  lcl_req, lcl_we, lcl_addr, lcl_wdata,
    input  bank_rdata,
    output spi_rdata, lcl_gnt, lcl_rvalid, lcl_rdata,
    output bank_addr, bank_wdata, bank_we, bank_re,
    output cfg_commit, spi_ovr
  );

  modport master (
    output spi_addr, spi_wdata, spi_wen, spi_ren, spi_done,
    output lcl_req, lcl_we, lcl_addr, lcl_wdata,
    output bank_rdata,
    input  spi_rdata, lcl_gnt, lcl_rvalid, lcl_rdata,
    input  bank_addr, bank_wdata, bank_we, bank_re,
    input  cfg_commit, spi_ovr
  );
endinterface
`default_nettype wire

// File: rtl/spi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// spi_reg_arbiter : SPI-priority arbiter for the config register bank port
// Revision 1.0
// ============================================================================
module spi_reg_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  spi_reg_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DIRTY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        tag_q, tag_d;          // {valid, owner: 1 = SPI}
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] spi_rdata_q;
  logic [DATA_W-1:0] lcl_rdata_q;
  logic              lcl_rvalid_q;
  logic              commit_q, commit_d;
  logic              ovr_q, ovr_d;

  logic              spi_acc_w;
  logic              we_w;
  logic              re_w;
  logic              gnt_w;

  assign spi_acc_w = bus.spi_wen | bus.spi_ren;

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_w    = 1'b0;
    re_w    = 1'b0;
    gnt_w   = 1'b0;
    tag_d   = 2'b00;
    if (spi_acc_w) begin
      addr_d  = bus.spi_addr;
      wdata_d = bus.spi_wdata;
      we_w    = bus.spi_wen;
      re_w    = bus.spi_ren & ~bus.spi_wen;
      tag_d   = {re_w, 1'b1};
    end else if (bus.lcl_req) begin
      addr_d  = bus.lcl_addr;
      wdata_d = bus.lcl_wdata;
      we_w    = bus.lcl_we;
      re_w    = ~bus.lcl_we;
      gnt_w   = 1'b1;
      tag_d   = {re_w, 1'b0};
    end
  end

  // Overrun: back-to-back SPI strobes behind a read, or a write/read collision.
  assign ovr_d = ovr_q
               | (spi_acc_w & (tag_q == 2'b11))
               | (bus.spi_wen & bus.spi_ren);

  always_comb begin
    state_d  = state_q;
    commit_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.spi_wen && bus.spi_done) begin
          commit_d = 1'b1;
        end else if (bus.spi_wen) begin
          state_d = S_DIRTY;
        end
      end
      S_DIRTY: begin
        if (bus.spi_done) begin
          state_d  = S_IDLE;
          commit_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tag_q        <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      spi_rdata_q  <= '0;
      lcl_rdata_q  <= '0;
      lcl_rvalid_q <= 1'b0;
      commit_q     <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      commit_q     <= commit_d;
      ovr_q        <= ovr_d;
      lcl_rvalid_q <= tag_q[1] & ~tag_q[0];
      if (tag_q == 2'b11) begin
        spi_rdata_q <= bus.bank_rdata;
      end
      if (tag_q == 2'b10) begin
        lcl_rdata_q <= bus.bank_rdata;
      end
    end
  end

  // The combinational issue path is gated so every output sits at its reset value during rst.
  assign bus.bank_addr  = rst ? '0 : addr_d;
  assign bus.bank_wdata = rst ? '0 : wdata_d;
  assign bus.bank_we    = we_w  & ~rst;
  assign bus.bank_re    = re_w  & ~rst;
  assign bus.lcl_gnt    = gnt_w & ~rst;
  assign bus.spi_rdata  = spi_rdata_q;
  assign bus.lcl_rdata  = lcl_rdata_q;
  assign bus.lcl_rvalid = lcl_rvalid_q;
  assign bus.cfg_commit = commit_q;
  assign bus.spi_ovr    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// tb_spi_reg_arbiter : randomized + directed bench with a transaction-level model
// Revision 1.0
// ============================================================================
module tb_spi_reg_arbiter;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  spi_reg_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spi_reg_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single-port bank: synchronous write, one-cycle read latency.
  logic [7:0] bank_mem [128] = '{default: 8'h00};
  logic [7:0] bank_rd_r = 8'h00;
  always @(posedge clk) begin
    if (bus.bank_we) bank_mem[bus.bank_addr] <= bus.bank_wdata;
    if (bus.bank_re) bank_rd_r <= bank_mem[bus.bank_addr];
  end
  assign bus.bank_rdata = bank_rd_r;

  // Reference model state
  typedef struct {
    int         due;
    bit         to_spi;
    logic [7:0] data;
  } rd_t;

  rd_t        pend[$];
  logic [7:0] ref_mem [128];
  logic [7:0] exp_spi_rdata, exp_lcl_rdata;
  bit         exp_ovr, wrote;
  int         commit_due, last_spi_rd, cyc, gap;

  bit         lreq, lwe, lcl_auto;
  logic [6:0] laddr;
  logic [7:0] lwdata;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    exp_spi_rdata = 8'h00;
    exp_lcl_rdata = 8'h00;
    exp_ovr       = 1'b0;
    wrote         = 1'b0;
    commit_due    = -1;
    last_spi_rd   = -10;
    gap           = 10;
    lreq          = 1'b0;
  endtask

  // One clock cycle: drive, predict, check at negedge, advance the model.
  task automatic step(input bit wen, input bit ren, input bit done,
                      input logic [6:0] sa, input logic [7:0] sd);
    bit         acc, e_gnt, e_we, e_re, e_rvalid;
    logic [6:0] e_addr;
    logic [7:0] e_wdata;
    if (lcl_auto && !lreq && $urandom_range(0, 99) < 50) begin
      lreq   = 1'b1;
      lwe    = 1'($urandom_range(0, 1));
      laddr  = 7'($urandom_range(0, 15));
      lwdata = 8'($urandom);
    end
    bus.spi_wen   = wen;
    bus.spi_ren   = ren;
    bus.spi_done  = done;
    bus.spi_addr  = sa;
    bus.spi_wdata = sd;
    bus.lcl_req   = lreq;
    bus.lcl_we    = lwe;
    bus.lcl_addr  = laddr;
    bus.lcl_wdata = lwdata;

    acc   = wen | ren;
    e_gnt = !acc && lreq;
    e_we  = acc ? wen : (e_gnt && lwe);
    e_re  = acc ? (ren && !wen) : (e_gnt && !lwe);
    e_addr  = acc ? sa : laddr;
    e_wdata = acc ? sd : lwdata;

    e_rvalid = 1'b0;
    while (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].to_spi) exp_spi_rdata = pend[0].data;
      else begin
        exp_lcl_rdata = pend[0].data;
        e_rvalid      = 1'b1;
      end
      void'(pend.pop_front());
    end

    @(negedge clk);
    chk("bank_we", 32'(bus.bank_we), 32'(e_we));
    chk("bank_re", 32'(bus.bank_re), 32'(e_re));
    chk("lcl_gnt", 32'(bus.lcl_gnt), 32'(e_gnt));
    if (e_we || e_re) chk("bank_addr", 32'(bus.bank_addr), 32'(e_addr));
    if (e_we)         chk("bank_wdata", 32'(bus.bank_wdata), 32'(e_wdata));
    chk("spi_rdata", 32'(bus.spi_rdata), 32'(exp_spi_rdata));
    chk("lcl_rdata", 32'(bus.lcl_rdata), 32'(exp_lcl_rdata));
    chk("lcl_rvalid", 32'(bus.lcl_rvalid), 32'(e_rvalid));
    chk("cfg_commit", 32'(bus.cfg_commit), 32'(commit_due == cyc));
    chk("spi_ovr", 32'(bus.spi_ovr), 32'(exp_ovr));

    if ((acc && last_spi_rd == cyc - 1) || (wen && ren)) exp_ovr = 1'b1;
    if (e_re) pend.push_back('{cyc + 2, acc, ref_mem[e_addr]});
    if (e_we) ref_mem[e_addr] = e_wdata;
    if (ren && !wen) last_spi_rd = cyc;
    wrote = wrote | wen;
    if (done) begin
      if (wrote) commit_due = cyc + 1;
      wrote = 1'b0;
    end
    if (e_gnt) lreq = 1'b0;
    gap = acc ? 0 : gap + 1;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
  endtask

  task automatic do_reset(input int n);
    rst         = 1'b1;
    bus.lcl_req = 1'b1;
    bus.spi_wen = 1'b0;
    bus.spi_ren = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_bank_we",    32'(bus.bank_we),    32'd0);
      chk("rst_bank_re",    32'(bus.bank_re),    32'd0);
      chk("rst_bank_addr",  32'(bus.bank_addr),  32'd0);
      chk("rst_bank_wdata", 32'(bus.bank_wdata), 32'd0);
      chk("rst_lcl_gnt",    32'(bus.lcl_gnt),    32'd0);
      chk("rst_lcl_rvalid", 32'(bus.lcl_rvalid), 32'd0);
      chk("rst_lcl_rdata",  32'(bus.lcl_rdata),  32'd0);
      chk("rst_spi_rdata",  32'(bus.spi_rdata),  32'd0);
      chk("rst_cfg_commit", 32'(bus.cfg_commit), 32'd0);
      chk("rst_spi_ovr",    32'(bus.spi_ovr),    32'd0);
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic rand_phase(input int n, input bit close_ok);
    lcl_auto = 1'b1;
    for (int i = 0; i < n; i++) begin
      bit wen, ren, done;
      int r, r2;
      wen = 1'b0; ren = 1'b0; done = 1'b0;
      r  = $urandom_range(0, 99);
      r2 = $urandom_range(0, 9);
      if ((close_ok && r < 35) || (!close_ok && gap >= 3 && r < 40)) begin
        if (r2 < 4)      wen = 1'b1;
        else if (r2 < 9) ren = 1'b1;
        else begin
          wen = close_ok;
          ren = 1'b1;
        end
      end
      if (close_ok || !(wen || ren)) done = ($urandom_range(0, 7) == 0);
      step(wen, ren, done, 7'($urandom_range(0, 15)), 8'($urandom));
    end
    lcl_auto = 1'b0;
    for (int i = 0; i < 3 && lreq; i++) idle(1);
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    cyc = 0; lcl_auto = 1'b0; lwe = 1'b0; laddr = '0; lwdata = '0;
    bus.spi_done = 1'b0; bus.spi_addr = '0; bus.spi_wdata = '0;
    bus.lcl_we = 1'b0; bus.lcl_addr = '0; bus.lcl_wdata = '0;
    model_clear();
    do_reset(3);

    // SPI write then chip-select release -> commit one cycle later
    step(1'b1, 1'b0, 1'b0, 7'h10, 8'h5A);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 7'h00, 8'h00);
    idle(2);

    // SPI read of a known value; done without writes must not commit
    step(1'b1, 1'b0, 1'b1, 7'h22, 8'hC3);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 7'h22, 8'h00);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 7'h00, 8'h00);
    idle(2);

    // Local read deferred behind an SPI write to the same address
    lreq = 1'b1; lwe = 1'b0; laddr = 7'h05; lwdata = 8'h00;
    step(1'b1, 1'b0, 1'b0, 7'h05, 8'h77);
    idle(4);
    step(1'b0, 1'b0, 1'b1, 7'h00, 8'h00);
    idle(2);

    // Back-to-back local writes, then read them back
    for (int k = 1; k <= 4; k++) begin
      lreq = 1'b1; lwe = 1'b1; laddr = 7'(k); lwdata = 8'(k);
      step(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    end
    for (int k = 1; k <= 4; k++) begin
      lreq = 1'b1; lwe = 1'b0; laddr = 7'(k);
      step(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    end
    idle(3);

    rand_phase(400, 1'b0);

    // Overrun: two SPI reads in consecutive cycles
    step(1'b0, 1'b1, 1'b0, 7'h10, 8'h00);
    step(1'b0, 1'b1, 1'b0, 7'h22, 8'h00);
    idle(4);

    rand_phase(400, 1'b1);

    // Reset one cycle after a local read grant: no rvalid may ever appear
    lreq = 1'b1; lwe = 1'b0; laddr = 7'h03;
    step(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    do_reset(2);
    idle(4);

    rand_phase(200, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/spi_reg_arbiter.md
# spi_reg_arbiter

Shares the single-port configuration register bank between the SPI target's register bus and one local requester (the bridge control FSM). SPI accesses are hard real-time and always win the bank port; local accesses use a req/gnt handshake and fill the idle cycles. The block also turns the SPI end-of-transaction strobe into a commit pulse that latches shadow configuration, and flags SPI accesses that arrive too close together.

## Interface
- ADDR_W, 7, register address width
- DATA_W, 8, register data width
- clk  in  1  system clock (48 MHz)
- rst  in  1  asynchronous reset, active-high
- spi_addr  in  ADDR_W  SPI-side address, valid when spi_wen or spi_ren is high
- spi_wdata  in  DATA_W  SPI-side write data
- spi_wen  in  1  SPI write strobe, single-cycle pulse
- spi_ren  in  1  SPI read strobe, single-cycle pulse
- spi_done  in  1  SPI chip-select release, single-cycle pulse
- spi_rdata  out  DATA_W  read data returned to the SPI target, held until the next SPI read completes
- lcl_req  in  1  local request; lcl_we, lcl_addr and lcl_wdata are held stable until lcl_gnt
- lcl_we  in  1  local write (1) or read (0)
- lcl_addr  in  ADDR_W  local address
- lcl_wdata  in  DATA_W  local write data
- lcl_gnt  out  1  one-cycle pulse: the local request is issued to the bank this cycle
- lcl_rvalid  out  1  one-cycle pulse: lcl_rdata is valid
- lcl_rdata  out  DATA_W  local read data, held until the next local read completes
- bank_addr  out  ADDR_W  bank address
- bank_wdata  out  DATA_W  bank write data
- bank_we  out  1  bank write enable
- bank_re  out  1  bank read enable
- bank_rdata  in  DATA_W  bank read data, valid one cycle after bank_re
- cfg_commit  out  1  one-cycle pulse when an SPI transaction that wrote at least one register ends
- spi_ovr  out  1  sticky flag: SPI access arrived while an earlier SPI read was still in flight

## Operation
- Bank-port issue is combinational in cycle N:
  - If spi_wen or spi_ren is high, issue the SPI access: bank_addr = spi_addr, bank_we = spi_wen, bank_re = spi_ren.
  - Otherwise, if lcl_req is high, issue the local access and assert lcl_gnt.
  - Otherwise bank_we = bank_re = 0; bank_addr and bank_wdata are don't-care but stable.
- spi_wen and spi_ren together in the same cycle: the write is performed, the read is ignored, and spi_ovr is set.
- Read return pipeline:
  - A 2-bit tag {valid, owner} is registered with every issued read.
  - In cycle N+1 the tag selects the destination; bank_rdata is captured into spi_rdata or lcl_rdata at the end of N+1.
  - For local reads, lcl_rvalid is asserted in cycle N+2, together with the updated lcl_rdata.
- Local handling:
  - A local request blocked by SPI waits; lcl_gnt follows in the first cycle without an SPI strobe.
  - The SPI target strobes at most once per 8 SCK, so the wait is at most 1 cycle.
  - The requester may drop lcl_req only after lcl_gnt.
- Overrun: an SPI strobe in cycle N+1 after an SPI read issued in N sets spi_ovr. The new access is still issued; the earlier read data is still delivered. spi_ovr clears only on rst.
- Commit FSM, states IDLE and DIRTY:
  - IDLE -> DIRTY on spi_wen.
  - DIRTY -> IDLE on spi_done, with cfg_commit high in the next cycle.
  - spi_done in IDLE: no commit.
  - spi_wen and spi_done in the same cycle: the write counts; commit the next cycle; end in IDLE.
  - Local writes never affect the commit FSM.
- Same-address ordering: SPI wins the port, so an SPI write lands before a local write that was deferred behind it. A local read issued after an SPI write returns the new value.

## Timing
- Reset values of every output: spi_rdata = 0, lcl_rdata = 0, lcl_gnt = 0, lcl_rvalid = 0, bank_we = 0, bank_re = 0, bank_addr = 0, bank_wdata = 0, cfg_commit = 0, spi_ovr = 0. The FSM is in IDLE and the tag pipe is empty.
- SPI read: strobe in N; spi_rdata is valid from N+2. This meets the spi_target falling-edge load for SCK ≤ 12 MHz (≥ 2 clk per half period).
- SPI write: the bank is written in the strobe cycle, with zero added latency.
- Local: lcl_gnt is combinational from lcl_req in a free cycle. Read data arrives 2 cycles after lcl_gnt.
- rst asserted mid-read: the tag pipe is flushed, no rvalid is issued, and the FSM returns to IDLE. The requester re-issues after reset.

## Test plan
- SPI write 0x5A to 0x10, then spi_done → bank_we in the strobe cycle with addr 0x10 and data 0x5A; cfg_commit high exactly 1 cycle after spi_done.
- SPI read of 0x22 (bank holds 0xC3) → bank_re in N; spi_rdata = 0xC3 from N+2; spi_ovr stays 0; no commit on spi_done.
- lcl_req read of 0x05 in the same cycle as spi_wen to 0x05 with 0x77 → no lcl_gnt in N; lcl_gnt in N+1; lcl_rvalid in N+3 with lcl_rdata = 0x77.
- Back-to-back local writes 0x01..0x04 with no SPI traffic → four consecutive lcl_gnt pulses; bank_we for 4 cycles with the matching addr and data.
- SPI read in N, then spi_ren again in N+1 → spi_ovr = 1 and stays set; both reads are issued; spi_rdata takes the second read's data at N+3.
- rst pulsed one cycle after a local read grant → lcl_rvalid never asserted; all outputs return to their reset values while rst is high.
